// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I funct3 width codes
// and the access-size decode used by both the FSM and the misalignment check.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANES = 4;

  // BU/HU codes only exist for loads; a store carrying them falls back to a word access.
  function automatic size_t accessSize(input logic we, input logic [2:0] funct3);
    size_t sz;
    sz = SZ_W;
    if (funct3 == F3_B || (!we && funct3 == F3_BU)) begin
      sz = SZ_B;
    end else if (funct3 == F3_H || (!we && funct3 == F3_HU)) begin
      sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the core request/response handshake and the data-memory port of the load/store unit.
// slave = the unit itself, master = its environment (core MEM stage plus data memory).
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD;
  logic              mem_WE;
  logic [DATA_W-1:0] mem_RD;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: sign/zero-extended sub-word extraction for loads and
// single-lane merge into the fetched word for SB/SH read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0]              i_word,
  input  logic [$clog2(LANES)-1:0] i_addr,
  input  logic [2:0]               i_funct3,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_extRdata,
  output logic [31:0]              o_mergedWdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
  always_comb begin
    w_byte = i_word[{i_addr, 3'b000} +: 8];
    w_half = i_word[{i_addr[1], 4'b0000} +: 16];
    case (i_funct3)
      F3_B:    o_extRdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_extRdata = {24'b0, w_byte};
      F3_H:    o_extRdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_extRdata = {16'b0, w_half};
      F3_W:    o_extRdata = i_word;
      default: o_extRdata = i_word;
    endcase
  end

  always_comb begin
    o_mergedWdata = i_word;
    case (i_funct3)
      F3_B:    o_mergedWdata[{i_addr, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_mergedWdata[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_mergedWdata = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-organised data memory (IDLE/RD/WR/RESP FSM, RMW for SB/SH).
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  state_t            r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addrLo;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_word;
  logic              r_reqReady;
  logic              r_respValid;
  logic [DATA_W-1:0] r_respRdata;
  logic              r_respErr;
  logic [ADDR_W-1:0] r_memA;
  logic [DATA_W-1:0] r_memWD;
  logic              r_memWE;

  size_t             w_reqSize;
  logic              w_trap;
  logic [DATA_W-1:0] w_alignWord;
  logic [DATA_W-1:0] w_extRdata;
  logic [DATA_W-1:0] w_mergedWdata;

  assign w_reqSize = accessSize(bus.req_we, bus.req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = (w_reqSize == SZ_H && bus.req_addr[0]) ||
                  (w_reqSize == SZ_W && bus.req_addr[1:0] != 2'b00);
`else
  assign w_trap = 1'b0;
`endif

  // The fetched word is only valid on the RD edge, so the align logic sees mem_RD directly there.
  assign w_alignWord = (r_state == RD) ? bus.mem_RD : r_word;

  lsu_align u_align (
    .i_word        (w_alignWord),
    .i_addr        (r_addrLo),
    .i_funct3      (r_funct3),
    .i_wdata       (r_wdata),
    .o_extRdata    (w_extRdata),
    .o_mergedWdata (w_mergedWdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addrLo    <= '0;
      r_wdata     <= '0;
      r_word      <= '0;
      r_reqReady  <= 1'b1;
      r_respValid <= 1'b0;
      r_respRdata <= '0;
      r_respErr   <= 1'b0;
      r_memA      <= '0;
      r_memWD     <= '0;
      r_memWE     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we       <= bus.req_we;
            r_funct3   <= bus.req_funct3;
            r_addrLo   <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata;
            r_reqReady <= 1'b0;
            if (w_trap) begin
              r_state     <= RESP;
              r_respValid <= 1'b1;
              r_respErr   <= 1'b1;
              r_respRdata <= '0;
            end else if (bus.req_we && w_reqSize == SZ_W) begin
              r_state <= WR;
              r_memA  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              r_memWE <= 1'b1;
              r_memWD <= bus.req_wdata;
            end else begin
              r_state <= RD;
              r_memA  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        RD: begin
          r_word <= bus.mem_RD;
          if (r_we) begin
            r_state <= WR;
            r_memWE <= 1'b1;
            r_memWD <= w_mergedWdata;
          end else begin
            r_state     <= RESP;
            r_respValid <= 1'b1;
            r_respRdata <= w_extRdata;
            r_respErr   <= 1'b0;
          end
        end
        WR: begin
          r_state     <= RESP;
          r_memWE     <= 1'b0;
          r_respValid <= 1'b1;
          r_respRdata <= '0;
          r_respErr   <= 1'b0;
        end
        RESP: begin
          r_state     <= IDLE;
          r_respValid <= 1'b0;
          r_reqReady  <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_memWE    <= 1'b0;
          r_reqReady <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_reqReady;
  assign bus.resp_valid = r_respValid;
  assign bus.resp_rdata = r_respRdata;
  assign bus.resp_err   = r_respErr;
  assign bus.mem_A      = r_memA;
  assign bus.mem_WD     = r_memWD;
  assign bus.mem_WE     = r_memWE;

endmodule
